// File: rtl/player_hit_detect_if.sv
// +----------------------------------------------------------------------------+
// | player_hit_detect_if                                                       |
// | Frame/missile-position inputs and collision/lives outputs of the player    |
// | hit detector.                                                              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface player_hit_detect_if;
   logic       frame;
   logic       restart;
   logic [9:0] player_x;
   logic [9:0] m1_x;
   logic [9:0] m1_y;
   logic [9:0] m2_x;
   logic [9:0] m2_y;
   logic [9:0] m3_x;
   logic [9:0] m3_y;
   logic [1:0] player_collision;
   logic [1:0] lives;
   logic       player_hit;
   logic       game_over;

   modport master (
      output frame, restart, player_x, m1_x, m1_y, m2_x, m2_y, m3_x, m3_y,
      input  player_collision, lives, player_hit, game_over
   );

   modport slave (
      input  frame, restart, player_x, m1_x, m1_y, m2_x, m2_y, m3_x, m3_y,
      output player_collision, lives, player_hit, game_over
   );
endinterface

`default_nettype wire

// File: rtl/player_hit_detect.sv
// +----------------------------------------------------------------------------+
// | player_hit_detect                                                          |
// | Per-frame missile/player overlap test, lives count and ALIVE/HIT/DEAD FSM. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module player_hit_detect #(
   parameter int PLAYER_Y   = 440,
   parameter int PLAYER_W   = 32,
   parameter int PLAYER_H   = 16,
   parameter int MISSILE_W  = 4,
   parameter int MISSILE_H  = 12,
   parameter int LIVES      = 3,
   parameter int HIT_FRAMES = 60
) (
   input  logic              clk,
   input  logic              rst_n,
   player_hit_detect_if.slave bus
);

   typedef enum logic [1:0] {
      ST_ALIVE = 2'd0,
      ST_HIT   = 2'd1,
      ST_DEAD  = 2'd2
   } state_t;

   localparam logic [10:0] c_player_w  = 11'(PLAYER_W);
   localparam logic [10:0] c_missile_w = 11'(MISSILE_W);
   localparam logic [10:0] c_missile_h = 11'(MISSILE_H);
   localparam logic [10:0] c_top       = 11'(PLAYER_Y);
   localparam logic [10:0] c_bottom    = 11'(PLAYER_Y + PLAYER_H);
   localparam logic [1:0]  c_lives     = 2'(LIVES);
   localparam logic [7:0]  c_hit_frames = 8'(HIT_FRAMES);

   state_t     r_state, w_state_nx;
   logic [1:0] r_lives, w_lives_nx;
   logic [1:0] r_coll, w_coll_nx;
   logic [7:0] r_hit_cnt, w_hit_cnt_nx;
   logic       r_frame_d;
   logic       r_player_hit;
   logic       r_game_over;

   logic [9:0] w_mx [3];
   logic [9:0] w_my [3];
   logic [2:0] w_overlap;
   logic [1:0] w_code;

   assign w_mx[0] = bus.m1_x;
   assign w_mx[1] = bus.m2_x;
   assign w_mx[2] = bus.m3_x;
   assign w_my[0] = bus.m1_y;
   assign w_my[1] = bus.m2_y;
   assign w_my[2] = bus.m3_y;

   // 11-bit sums so the right/bottom edges never wrap
   for (genvar i = 0; i < 3; i++) begin : g_missile
      logic [10:0] w_x, w_y, w_px;
      assign w_x  = {1'b0, w_mx[i]};
      assign w_y  = {1'b0, w_my[i]};
      assign w_px = {1'b0, bus.player_x};
      assign w_overlap[i] = (w_x < w_px + c_player_w) &&
                            (w_x + c_missile_w > w_px) &&
                            (w_y < c_bottom) &&
                            (w_y + c_missile_h > c_top);
   end

   always_comb begin
      w_code = 2'd0;
      if (w_overlap[0])
         w_code = 2'd1;
      else if (w_overlap[1])
         w_code = 2'd2;
      else if (w_overlap[2])
         w_code = 2'd3;
   end

   always_comb begin
      w_state_nx   = r_state;
      w_lives_nx   = r_lives;
      w_coll_nx    = 2'd0;
      w_hit_cnt_nx = r_hit_cnt;
      if (bus.restart) begin
         w_state_nx   = ST_ALIVE;
         w_lives_nx   = c_lives;
         w_hit_cnt_nx = 8'd0;
      end else begin
         case (r_state)
            ST_ALIVE: begin
               if (r_frame_d && (w_code != 2'd0)) begin
                  w_coll_nx  = w_code;
                  w_lives_nx = r_lives - 2'd1;
                  if (r_lives == 2'd1) begin
                     w_state_nx = ST_DEAD;
                  end else begin
                     w_state_nx   = ST_HIT;
                     w_hit_cnt_nx = c_hit_frames;
                  end
               end
            end
            ST_HIT: begin
               // Still report so the missile block recycles, but no life lost
               if (r_frame_d)
                  w_coll_nx = w_code;
               if (bus.frame) begin
                  w_hit_cnt_nx = r_hit_cnt - 8'd1;
                  if (r_hit_cnt == 8'd1)
                     w_state_nx = ST_ALIVE;
               end
            end
            default: begin
               w_state_nx = ST_DEAD;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_ALIVE;
         r_lives      <= c_lives;
         r_coll       <= 2'd0;
         r_hit_cnt    <= 8'd0;
         r_frame_d    <= 1'b0;
         r_player_hit <= 1'b0;
         r_game_over  <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_lives      <= w_lives_nx;
         r_coll       <= w_coll_nx;
         r_hit_cnt    <= w_hit_cnt_nx;
         r_frame_d    <= bus.frame;
         r_player_hit <= (w_state_nx == ST_HIT);
         r_game_over  <= (w_state_nx == ST_DEAD);
      end
   end

   assign bus.player_collision = r_coll;
   assign bus.lives            = r_lives;
   assign bus.player_hit       = r_player_hit;
   assign bus.game_over        = r_game_over;

endmodule

`default_nettype wire
